// File: rtl/sort_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sort_sched
//  Description : Sequencer that owns a single-port sort array and shares it
//                between a host input stream (LOAD), a selection-sort engine
//                (KICK/SORT) and a host output stream (UNLOAD).
//  Revision    : 1.0 - initial release
// ============================================================================
module sort_sched #(
  parameter int NUM_ROWS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  // host input stream
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  // host output stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  // sort engine side
  output logic              srt_start,
  input  logic              srt_done,
  input  logic [ADDR_W-1:0] srt_rd_addr,
  output logic [DATA_W-1:0] srt_rd_data,
  input  logic              srt_wr_en,
  input  logic [ADDR_W-1:0] srt_wr_addr,
  input  logic [DATA_W-1:0] srt_wr_data,
  // array side
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  // Gray-coded so every legal transition flips exactly one bit.
  typedef enum logic [1:0] {
    LOAD   = 2'b00,
    KICK   = 2'b01,
    SORT   = 2'b11,
    UNLOAD = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_row = ADDR_W'(NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;

  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_ptr_last;

  assign w_in_fire  = in_valid  && (r_state == LOAD);
  assign w_out_fire = out_ready && (r_state == UNLOAD);
  assign w_ptr_last = (r_ptr == c_last_row);

  // Sequencer state and the shared LOAD/UNLOAD row pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_fire) begin
            if (w_ptr_last) begin
              r_ptr   <= '0;
              r_state <= KICK;
            end else begin
              r_ptr <= r_ptr + c_one;
            end
          end
        end
        KICK: begin
          r_state <= SORT;
        end
        SORT: begin
          if (srt_done) begin
            r_ptr   <= '0;
            r_state <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (w_out_fire) begin
            if (w_ptr_last) begin
              r_ptr   <= '0;
              r_state <= LOAD;
            end else begin
              r_ptr <= r_ptr + c_one;
            end
          end
        end
        default: begin
          r_ptr   <= '0;
          r_state <= LOAD;
        end
      endcase
    end
  end

  // Host-facing handshake and status, decoded from the state register.
  always_comb begin
    in_ready  = (r_state == LOAD);
    out_valid = (r_state == UNLOAD);
    out_last  = (r_state == UNLOAD) && w_ptr_last;
    out_data  = (r_state == UNLOAD) ? mem_rd_data : '0;
    busy      = (r_state == KICK) || (r_state == SORT);
    srt_start = (r_state == KICK);
  end

  // Array port mux: host write in LOAD, engine in SORT, ptr read in UNLOAD.
  // Writes are suppressed in the reset cycle so an abort never touches the array.
  always_comb begin
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    srt_rd_data = '0;
    case (r_state)
      LOAD: begin
        mem_wr_en   = w_in_fire && !rst;
        mem_wr_addr = r_ptr;
        mem_wr_data = in_data;
      end
      SORT: begin
        mem_rd_addr = srt_rd_addr;
        srt_rd_data = mem_rd_data;
        mem_wr_en   = srt_wr_en && !rst;
        mem_wr_addr = srt_wr_addr;
        mem_wr_data = srt_wr_data;
      end
      UNLOAD: begin
        mem_rd_addr = r_ptr;
      end
      default: begin
        mem_rd_addr = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sort_sched
//  Description : Self-checking bench for sort_sched with a behavioural array
//                and a read-all / sort / write-back engine model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_sched;

  localparam int NUM_ROWS = 4;
  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              srt_start;
  logic              srt_done;
  logic [ADDR_W-1:0] srt_rd_addr;
  logic [DATA_W-1:0] srt_rd_data;
  logic              srt_wr_en;
  logic [ADDR_W-1:0] srt_wr_addr;
  logic [DATA_W-1:0] srt_wr_data;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  sort_sched #(.NUM_ROWS(NUM_ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy),
    .srt_start(srt_start), .srt_done(srt_done),
    .srt_rd_addr(srt_rd_addr), .srt_rd_data(srt_rd_data),
    .srt_wr_en(srt_wr_en), .srt_wr_addr(srt_wr_addr), .srt_wr_data(srt_wr_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  // Single-port array: combinational read, synchronous write.
  logic [DATA_W-1:0] mem [NUM_ROWS];
  assign mem_rd_data = mem[mem_rd_addr];
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  // Engine model: read every row, then write back the sorted rows; done on last write.
  int                eng_ph;
  logic [ADDR_W-1:0] eng_idx;
  logic [DATA_W-1:0] eng_buf [NUM_ROWS];
  logic [DATA_W-1:0] eng_srt [NUM_ROWS];
  assign srt_rd_addr = eng_idx;
  assign srt_wr_en   = (eng_ph == 2);
  assign srt_wr_addr = eng_idx;
  assign srt_wr_data = eng_srt[eng_idx];
  assign srt_done    = (eng_ph == 2) && (eng_idx == ADDR_W'(NUM_ROWS - 1));

  always_comb begin
    logic [DATA_W-1:0] t;
    for (int i = 0; i < NUM_ROWS; i++) eng_srt[i] = eng_buf[i];
    for (int i = 0; i < NUM_ROWS - 1; i++)
      for (int j = 0; j < NUM_ROWS - 1 - i; j++)
        if (eng_srt[j] > eng_srt[j+1]) begin
          t = eng_srt[j]; eng_srt[j] = eng_srt[j+1]; eng_srt[j+1] = t;
        end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eng_ph  <= 0;
      eng_idx <= '0;
    end else begin
      case (eng_ph)
        0: if (srt_start) begin eng_ph <= 1; eng_idx <= '0; end
        1: begin
          eng_buf[eng_idx] <= srt_rd_data;
          eng_idx <= eng_idx + 1'b1;
          if (eng_idx == ADDR_W'(NUM_ROWS - 1)) eng_ph <= 2;
        end
        default: begin
          eng_idx <= eng_idx + 1'b1;
          if (eng_idx == ADDR_W'(NUM_ROWS - 1)) eng_ph <= 0;
        end
      endcase
    end
  end

  // Write / start monitor: host writes must be sequential from 0, none in KICK/UNLOAD/reset.
  int                host_wr_cnt = 0;
  int                bad_wr      = 0;
  int                start_cnt   = 0;
  logic [ADDR_W-1:0] exp_addr    = '0;
  always @(posedge clk) begin
    if (srt_start) start_cnt <= start_cnt + 1;
    if (rst) begin
      exp_addr <= '0;
      if (mem_wr_en) bad_wr <= bad_wr + 1;
    end else if (mem_wr_en) begin
      if (srt_start || out_valid) bad_wr <= bad_wr + 1;
      if (!busy) begin
        host_wr_cnt <= host_wr_cnt + 1;
        exp_addr    <= exp_addr + 1'b1;
        if (mem_wr_addr != exp_addr) bad_wr <= bad_wr + 1;
      end
    end
  end

  // Feed four words (first word in bits 31:24); push the sorted expectation.
  task automatic load_words(input logic [31:0] words, input bit gap, input bit hold9);
    logic [DATA_W-1:0] d [NUM_ROWS];
    logic [DATA_W-1:0] t;
    for (int i = 0; i < NUM_ROWS; i++) d[i] = words[31-8*i -: 8];
    for (int i = 0; i < NUM_ROWS; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL load_ready word %0d: got %b want 1", i, in_ready);
      end
      @(negedge clk);
      if (gap && i != NUM_ROWS - 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = hold9;
    in_data  = 8'd9;
    checks++;
    if (srt_start !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL kick: start=%b busy=%b in_ready=%b want 1 1 0", srt_start, busy, in_ready);
    end
    for (int i = 0; i < NUM_ROWS - 1; i++)
      for (int j = 0; j < NUM_ROWS - 1 - i; j++)
        if (d[j] > d[j+1]) begin t = d[j]; d[j] = d[j+1]; d[j+1] = t; end
    for (int i = 0; i < NUM_ROWS; i++) exp_q.push_back(d[i]);
  endtask

  // From KICK, wait for done; busy must hold and first word must follow done by one cycle.
  task automatic wait_sort(input int start0);
    bit seen_done = 0;
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (seen_done) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL first_word_latency: out_valid=%b want 1", out_valid);
        end
        ok = 1;
        break;
      end
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL sort_status: busy=%b out_valid=%b in_ready=%b want 1 0 0", busy, out_valid, in_ready);
      end
      if (srt_done === 1'b1) seen_done = 1;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL sort_timeout: no srt_done within 200 cycles");
    end
    checks++;
    if (start_cnt - start0 != 1) begin
      errors++; $display("FAIL start_pulses: got %0d want 1", start_cnt - start0);
    end
  endtask

  // Drain four words against the scoreboard, optionally stalling 5 cycles on one word.
  task automatic unload_words(input int stall_idx);
    logic [DATA_W-1:0] exp;
    for (int k = 0; k < NUM_ROWS; k++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL scoreboard_empty at word %0d", k);
        exp = '0;
      end else begin
        exp = exp_q.pop_front();
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || out_last !== (k == NUM_ROWS - 1) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL out_word %0d: valid=%b data=%0d last=%b in_ready=%b want 1 %0d %b 0",
                 k, out_valid, out_data, out_last, in_ready, exp, (k == NUM_ROWS - 1));
      end
      if (k == NUM_ROWS - 1) in_valid = 1'b0;
      if (k == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out_data !== exp) begin
            errors++;
            $display("FAIL stall_hold cycle %0d: valid=%b data=%0d want 1 %0d", s, out_valid, out_data, exp);
          end
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_load: out_valid=%b last=%b in_ready=%b busy=%b want 0 0 1 0",
               out_valid, out_last, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
        srt_start !== 1'b0 || mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b ov=%b last=%b busy=%b start=%b we=%b want 1 0 0 0 0 0",
               in_ready, out_valid, out_last, busy, srt_start, mem_wr_en);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int s0 = start_cnt;
    load_words({8'd3, 8'd1, 8'd2, 8'd0}, 1'b0, 1'b0);
    wait_sort(s0);
    unload_words(-1);
  endtask

  task automatic test_gaps();
    int w0 = host_wr_cnt;
    int s0 = start_cnt;
    load_words({8'd5, 8'd5, 8'd0, 8'd5}, 1'b1, 1'b0);
    wait_sort(s0);
    unload_words(-1);
    checks++;
    if (host_wr_cnt - w0 != NUM_ROWS) begin
      errors++; $display("FAIL gap_write_count: got %0d want %0d", host_wr_cnt - w0, NUM_ROWS);
    end
  endtask

  task automatic test_backpressure();
    int s0 = start_cnt;
    load_words({8'd7, 8'd2, 8'd9, 8'd4}, 1'b0, 1'b0);
    wait_sort(s0);
    unload_words(1);
  endtask

  task automatic test_ignore_input();
    int s0 = start_cnt;
    int w0 = host_wr_cnt;
    load_words({8'd3, 8'd1, 8'd2, 8'd0}, 1'b0, 1'b1);
    wait_sort(s0);
    unload_words(-1);
    checks++;
    if (host_wr_cnt - w0 != NUM_ROWS) begin
      errors++; $display("FAIL ignore_input_writes: got %0d want %0d", host_wr_cnt - w0, NUM_ROWS);
    end
  endtask

  task automatic test_reset_mid_sort();
    int  s0 = start_cnt;
    bit  hit = 0;
    load_words({8'd3, 8'd1, 8'd2, 8'd0}, 1'b0, 1'b0);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (mem_wr_en === 1'b1) begin hit = 1; break; end
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL mid_sort_write_seen: no engine write within 100 cycles");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_cycle_write: mem_wr_en=%b want 0", mem_wr_en);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || mem_wr_en !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_abort: in_ready=%b busy=%b we=%b ov=%b want 1 0 0 0",
               in_ready, busy, mem_wr_en, out_valid);
    end
    rst = 1'b0;
    exp_q.delete();
    s0 = start_cnt;
    load_words({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 1'b0);
    wait_sort(s0);
    unload_words(-1);
  endtask

  task automatic test_back_to_back();
    int s0 = start_cnt;
    load_words({8'd10, 8'd200, 8'd30, 8'd0}, 1'b0, 1'b0);
    wait_sort(s0);
    unload_words(-1);
    s0 = start_cnt;
    load_words({8'd255, 8'd128, 8'd1, 8'd64}, 1'b0, 1'b0);
    wait_sort(s0);
    unload_words(-1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_ignore_input();
    test_reset_mid_sort();
    test_back_to_back();
    checks++;
    if (bad_wr != 0) begin
      errors++; $display("FAIL illegal_writes: got %0d want 0", bad_wr);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_sched.md
Name: sort_sched

Overview:
- Top-level sequencer that owns the single-port sort array and time-shares it between a host stream interface and the selection-sort engine.
- Cycle: LOAD accepts NUM_ROWS words from an input stream, KICK starts the sort engine, SORT hands the array ports to the engine until it reports done, UNLOAD streams the sorted array out, then back to LOAD.
- Sits between the host streams, the array, and the sort engine's start/done and array ports.

Parameters:
- NUM_ROWS, 16, number of array entries; must match the sort engine's row count; at least 2.
- ADDR_W, 4, array address width; 2**ADDR_W >= NUM_ROWS.
- DATA_W, 8, array data width; unsigned compare in the engine.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  host input word valid
- in_ready  out  1  block accepts input; a transfer is in_valid & in_ready
- in_data  in  DATA_W  host input word
- out_valid  out  1  sorted output word valid
- out_ready  in  1  host accepts output
- out_data  out  DATA_W  sorted output word
- out_last  out  1  marks the final output word (index NUM_ROWS-1)
- busy  out  1  high in KICK and SORT
- srt_start  out  1  one-cycle start pulse to the sort engine
- srt_done  in  1  sort engine done pulse
- srt_rd_addr  in  ADDR_W  engine read address
- srt_rd_data  out  DATA_W  read data to the engine
- srt_wr_en  in  1  engine write enable
- srt_wr_addr  in  ADDR_W  engine write address
- srt_wr_data  in  DATA_W  engine write data
- mem_rd_addr  out  ADDR_W  array read address; combinational read
- mem_rd_data  in  DATA_W  array read data, valid in the same cycle as mem_rd_addr
- mem_wr_en  out  1  array write enable
- mem_wr_addr  out  ADDR_W  array write address
- mem_wr_data  out  DATA_W  array write data

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state (next edge after rst): state=LOAD, ptr=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_last=0, busy=0, srt_start=0, mem_wr_en=0.
  - rst also resets the sort engine; no handshake with the engine on reset.
- Reset mid-operation (any state): abandon the operation. Array contents are left as-is; no write occurs in the reset cycle.
- State encoding: LOAD=2'b00, KICK=2'b01, SORT=2'b11, UNLOAD=2'b10 (gray). A single ADDR_W-bit ptr is shared by LOAD and UNLOAD.
- LOAD:
  - in_ready=1.
  - On each transfer: mem_wr_en=1, mem_wr_addr=ptr, mem_wr_data=in_data, ptr++.
  - Transfer with ptr==NUM_ROWS-1: ptr<=0, next state KICK.
  - Idle cycles (in_valid=0) write nothing.
  - mem_rd_addr=0.
- KICK (exactly 1 cycle):
  - srt_start=1, busy=1, in_ready=0, no writes.
  - Next state SORT.
- SORT:
  - busy=1.
  - Array ports are muxed to the engine: mem_rd_addr=srt_rd_addr, srt_rd_data=mem_rd_data, mem_wr_en/addr/data = srt_wr_en/addr/data.
  - in_ready=0, out_valid=0.
  - On srt_done=1: next state UNLOAD, ptr=0. A write asserted by the engine in the done cycle is still passed through.
  - No timeout.
- Outside SORT:
  - srt_rd_data=0.
  - srt_wr_en from the engine is ignored (not forwarded).
  - srt_done is ignored.
- UNLOAD:
  - mem_rd_addr=ptr, out_data=mem_rd_data (combinational), out_valid=1, out_last=(ptr==NUM_ROWS-1).
  - ptr and out_data hold while out_ready=0.
  - On out_valid & out_ready: ptr++. On the last word: ptr<=0, next state LOAD.
  - First output word appears the cycle after srt_done.
  - No writes. in_ready=0.
- Simultaneous events:
  - in_valid is never accepted outside LOAD.
  - out_ready outside UNLOAD has no effect.
- Throughput: with continuous valid/ready, one word per cycle in LOAD and UNLOAD.
  - Total = NUM_ROWS + 1 + sort cycles + NUM_ROWS.

Test Plan:
- NUM_ROWS=4, DATA_W=8. Load 3,1,2,0 back-to-back, out_ready=1:
  - srt_start pulses once, 1 cycle after the 4th accept; busy high through done.
  - Output 0,1,2,3; out_last only on 3; state returns to LOAD with in_ready=1.
- Load 5,5,0,5 with in_valid gaps (valid every other cycle):
  - Only 4 writes, addresses 0..3; output 0,5,5,5.
- Output backpressure: hold out_ready=0 for 5 cycles on the 2nd word:
  - out_valid stays 1, out_data stays constant, ptr does not advance.
  - No word is dropped or duplicated.
- Drive in_valid=1 with value 9 during KICK, SORT and UNLOAD:
  - in_ready=0 throughout; array not corrupted; output still the sorted first load.
- Assert rst for 1 cycle mid-SORT:
  - Next cycle: state LOAD, in_ready=1, busy=0, mem_wr_en=0.
  - A fresh load of 4,3,2,1 then sorts to 1,2,3,4.
- Two back-to-back full load/sort/unload passes with different data:
  - The second output matches the second input sorted.
  - No stale out_valid between passes.
